// File: rtl/uart_reg_responder.sv
// uart_reg_responder: decodes framed register commands arriving from a UART
// receiver, reads/writes a bank of 8-bit control registers and returns one
// response byte per frame to the UART transmitter.
//   write : 'W' addr data -> 'K'      read : 'R' addr -> reg value
//   unknown opcode or out-of-range address -> '?'
// A frame left idle for kTimeoutCycles cycles is abandoned without a response.
module uart_reg_responder #(
    parameter int kNumRegs       = 16,
    parameter int kTimeoutCycles = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [8*kNumRegs-1:0] reg_q,
    output logic                  reg_wr,
    output logic [7:0]            reg_wr_addr,
    output logic                  rx_dropped
);

    localparam int IDX_W = (kNumRegs > 1) ? $clog2(kNumRegs) : 1;
    localparam int CNT_W = $clog2(kTimeoutCycles) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(kTimeoutCycles - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [7:0] OP_WR    = 8'h57;
    localparam logic [7:0] OP_RD    = 8'h52;
    localparam logic [7:0] RESP_OK  = 8'h4B;
    localparam logic [7:0] RESP_ERR = 8'h3F;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_ADDR = 2'd1,
        GET_DATA = 2'd2,
        SEND     = 2'd3
    } state_t;

    // Full 8-bit address compare: no aliasing of high addresses onto the bank.
    function automatic logic addr_ok(input logic [7:0] a);
        return ({1'b0, a} < 9'(kNumRegs));
    endfunction

    state_t           state_r, state_s;
    logic             is_wr_r, is_wr_s;
    logic [7:0]       addr_r, addr_s;
    logic [7:0]       tx_data_r, tx_data_s;
    logic             tx_valid_r;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             wr_en_s;
    logic             drop_s;
    logic             reg_wr_r;
    logic [7:0]       reg_wr_addr_r;
    logic             rx_dropped_r;
    logic [7:0]       bank_r [kNumRegs];

    // Next-state, response selection, write strobe and idle-timeout counting.
    always_comb begin
        state_s   = state_r;
        is_wr_s   = is_wr_r;
        addr_s    = addr_r;
        tx_data_s = tx_data_r;
        cnt_s     = cnt_r;
        wr_en_s   = 1'b0;
        drop_s    = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = CNT_ZERO;
                if (rx_valid) begin
                    if (rx_data == OP_WR) begin
                        is_wr_s = 1'b1;
                        state_s = GET_ADDR;
                    end else if (rx_data == OP_RD) begin
                        is_wr_s = 1'b0;
                        state_s = GET_ADDR;
                    end else begin
                        tx_data_s = RESP_ERR;
                        state_s   = SEND;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    // A byte on the timeout edge still wins.
                    addr_s = rx_data;
                    cnt_s  = CNT_ZERO;
                    if (is_wr_r) begin
                        state_s = GET_DATA;
                    end else begin
                        state_s = SEND;
                        if (addr_ok(rx_data)) begin
                            tx_data_s = bank_r[rx_data[IDX_W-1:0]];
                        end else begin
                            tx_data_s = RESP_ERR;
                        end
                    end
                end else if (cnt_r == CNT_LAST) begin
                    cnt_s   = CNT_ZERO;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    cnt_s   = CNT_ZERO;
                    state_s = SEND;
                    if (addr_ok(addr_r)) begin
                        wr_en_s   = 1'b1;
                        tx_data_s = RESP_OK;
                    end else begin
                        tx_data_s = RESP_ERR;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    cnt_s   = CNT_ZERO;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            SEND: begin
                cnt_s = CNT_ZERO;
                // No backpressure toward the receiver: bytes here are lost.
                if (rx_valid) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = 1'b0;
                end
                if (tx_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = SEND;
                end
            end
            default: begin
                cnt_s   = CNT_ZERO;
                state_s = IDLE;
            end
        endcase
    end

    // Control state and registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            is_wr_r       <= 1'b0;
            addr_r        <= 8'h00;
            tx_data_r     <= 8'h00;
            tx_valid_r    <= 1'b0;
            cnt_r         <= CNT_ZERO;
            reg_wr_r      <= 1'b0;
            reg_wr_addr_r <= 8'h00;
            rx_dropped_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            is_wr_r      <= is_wr_s;
            addr_r       <= addr_s;
            tx_data_r    <= tx_data_s;
            tx_valid_r   <= (state_s == SEND);
            cnt_r        <= cnt_s;
            reg_wr_r     <= wr_en_s;
            rx_dropped_r <= drop_s;
            if (wr_en_s) begin
                reg_wr_addr_r <= addr_r;
            end
        end
    end

    // Register bank storage; written with the final byte of a valid write frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < kNumRegs; i++) begin
                bank_r[i] <= 8'h00;
            end
        end else if (wr_en_s) begin
            bank_r[addr_r[IDX_W-1:0]] <= rx_data;
        end
    end

    genvar g;
    generate
        for (g = 0; g < kNumRegs; g++) begin : g_flat
            assign reg_q[8*g +: 8] = bank_r[g];
        end
    endgenerate

    assign tx_data     = tx_data_r;
    assign tx_valid    = tx_valid_r;
    assign reg_wr      = reg_wr_r;
    assign reg_wr_addr = reg_wr_addr_r;
    assign rx_dropped  = rx_dropped_r;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench for uart_reg_responder: stimulus tasks push expected
// response bytes and write addresses; monitors pop and compare on transfers.
module tb_uart_reg_responder;

    localparam int NREGS = 16;
    localparam int TMO   = 100;

    logic                clk = 1'b0;
    logic                rst;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [8*NREGS-1:0]  reg_q;
    logic                reg_wr;
    logic [7:0]          reg_wr_addr;
    logic                rx_dropped;

    int tests = 0;
    int fails = 0;
    int xfers = 0;
    bit rdy_mode;     // 1: random tx_ready, 0: forced
    bit rdy_force;

    logic [7:0] mreg [NREGS];
    logic [7:0] exp_q[$];
    logic [7:0] wq[$];

    uart_reg_responder #(.kNumRegs(NREGS), .kTimeoutCycles(TMO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .reg_q(reg_q), .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr),
        .rx_dropped(rx_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8*NREGS-1:0] model_flat();
        logic [8*NREGS-1:0] f;
        for (int i = 0; i < NREGS; i++) f[8*i +: 8] = mreg[i];
        return f;
    endfunction

    task automatic check_bank(input string name);
        logic [8*NREGS-1:0] e;
        e = model_flat();
        tests++;
        if (reg_q !== e) begin
            fails++;
            $display("FAIL %s: reg_q got %h, expected %h", name, reg_q, e);
        end
    endtask

    // One-cycle rx strobe; the byte is taken on the second edge after the call.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || tx_valid) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 1000) check({name, "_timeout"}, c, 0);
    endtask

    // Reference model: expected response of a complete frame.
    task automatic run_frame(input logic [7:0] op, input logic [7:0] a,
                             input logic [7:0] d, input string name);
        int n;
        n = 1;
        if (op == 8'h57) begin
            n = 3;
            if (a < NREGS) begin
                mreg[a] = d;
                wq.push_back(a);
                exp_q.push_back(8'h4B);
            end else begin
                exp_q.push_back(8'h3F);
            end
        end else if (op == 8'h52) begin
            n = 2;
            exp_q.push_back((a < NREGS) ? mreg[a] : 8'h3F);
        end else begin
            exp_q.push_back(8'h3F);
        end
        send_byte(op);
        if (n > 1) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_byte(a);
        end
        if (n > 2) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_byte(d);
        end
        check({name, "_latency"}, int'(tx_valid), 1);
        check_bank({name, "_bank"});
        wait_idle(name);
    endtask

    // tx_ready driver.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Monitor: response transfers and write strobes against the scoreboard.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_valid && tx_ready) begin
                    xfers++;
                    if (exp_q.size() == 0) begin
                        check("tx_unexpected", int'(tx_data), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", int'(tx_data), int'(e));
                    end
                end
                if (reg_wr) begin
                    if (wq.size() == 0) begin
                        check("wr_unexpected", int'(reg_wr_addr), -1);
                    end else begin
                        e = wq.pop_front();
                        check("wr_addr", int'(reg_wr_addr), int'(e));
                    end
                end
            end
        end
    end

    initial begin
        int x0;
        bit ok;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        rdy_mode = 1'b1; rdy_force = 1'b0;
        for (int i = 0; i < NREGS; i++) mreg[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_reg_wr", int'(reg_wr), 0);
        check("rst_wr_addr", int'(reg_wr_addr), 0);
        check("rst_dropped", int'(rx_dropped), 0);
        check_bank("rst_bank");

        run_frame(8'h52, 8'h00, 8'h00, "rd0_after_rst");
        run_frame(8'h57, 8'h03, 8'hA5, "wr3");
        run_frame(8'h52, 8'h03, 8'h00, "rd3");
        run_frame(8'h00, 8'h00, 8'h00, "bad_op");
        run_frame(8'h57, 8'h10, 8'h55, "wr_bad_addr");
        run_frame(8'h52, 8'hFF, 8'h00, "rd_bad_addr");

        // Abandoned write, then read of the untouched register.
        send_byte(8'h57);
        send_byte(8'h02);
        repeat (TMO + 50) @(posedge clk);
        #1;
        check("timeout_no_tx", int'(tx_valid), 0);
        check("timeout_xfers", exp_q.size(), 0);
        run_frame(8'h52, 8'h02, 8'h00, "rd_after_tmo");

        // Address byte on the very last cycle before timeout is still accepted.
        mreg[5] = 8'h77; wq.push_back(8'h05); exp_q.push_back(8'h4B);
        send_byte(8'h57);
        repeat (TMO - 2) @(posedge clk);
        send_byte(8'h05);
        send_byte(8'h77);
        wait_idle("tmo_edge_ok");
        check_bank("tmo_edge_bank");
        // One cycle later the frame is gone: the byte is decoded as an opcode.
        exp_q.push_back(8'h3F);
        send_byte(8'h57);
        repeat (TMO - 1) @(posedge clk);
        send_byte(8'h05);
        check("tmo_edge_late", int'(tx_valid), 1);
        wait_idle("tmo_edge_late");
        check_bank("tmo_late_bank");

        // Randomized frames.
        for (int k = 0; k < 60; k++) begin
            int sel;
            logic [7:0] op;
            sel = $urandom_range(0, 9);
            if (sel < 4) op = 8'h57;
            else if (sel < 8) op = 8'h52;
            else begin
                op = 8'($urandom_range(0, 255));
                if (op == 8'h57 || op == 8'h52) op = 8'h00;
            end
            run_frame(op, 8'($urandom_range(0, 20)), 8'($urandom_range(0, 255)), "rand");
        end

        // Backpressure: hold tx_ready low, drop a byte, release.
        rdy_mode = 1'b0; rdy_force = 1'b0;
        @(posedge clk); #2;
        exp_q.push_back(mreg[3]);
        send_byte(8'h52);
        send_byte(8'h03);
        check("hold_latency", int'(tx_valid), 1);
        x0 = xfers;
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!tx_valid || tx_data != mreg[3]) ok = 1'b0;
            if (i == 50) begin
                send_byte(8'h57);
                check("rx_dropped", int'(rx_dropped), 1);
            end
        end
        check("hold_stable", int'(ok), 1);
        check("hold_no_xfer", xfers - x0, 0);
        rdy_force = 1'b1;
        wait_idle("hold_release");
        repeat (20) @(negedge clk);
        check("hold_one_xfer", xfers - x0, 1);
        check("hold_after_valid", int'(tx_valid), 0);
        check_bank("hold_bank");

        // Reset mid-frame.
        rdy_mode = 1'b1;
        send_byte(8'h57);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < NREGS; i++) mreg[i] = 8'h00;
        check("rst_mid_valid", int'(tx_valid), 0);
        check_bank("rst_mid_bank");
        #3 rst = 1'b0;
        run_frame(8'h52, 8'h01, 8'h00, "rd1_after_rst");

        // Reset while a response is pending.
        run_frame(8'h57, 8'h04, 8'h3C, "wr4");
        rdy_mode = 1'b0; rdy_force = 1'b0;
        @(posedge clk); #2;
        send_byte(8'h52);
        send_byte(8'h04);
        check("pend_valid", int'(tx_valid), 1);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < NREGS; i++) mreg[i] = 8'h00;
        check("rst_send_valid", int'(tx_valid), 0);
        #3 rst = 1'b0;
        x0 = xfers;
        rdy_mode = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_send_lost", xfers - x0, 0);
        run_frame(8'h52, 8'h04, 8'h00, "rd4_after_rst");

        check("final_exp_empty", exp_q.size(), 0);
        check("final_wq_empty", wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
